step_sequencer: RTL

//  Upstream command stage for PulseGen on one plotter motor axis. Accepts a signed step

---
 rtl/step_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/step_sequencer.sv
// Command stage ahead of PulseGen for one motor axis: sets dir, splits a signed step
// request into PulseGen-sized chunks, triggers one chunk at a time and tracks position.
module step_sequencer #(
    parameter int unsigned STEPS_BITS       = 16,
    parameter int unsigned PULSE_NUM_BITS   = 8,
    parameter int unsigned PULSE_WIDTH_BITS = 8,
    parameter int unsigned DIR_SETUP_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [STEPS_BITS-1:0]       steps,
    input  logic [PULSE_WIDTH_BITS-1:0] pulse_width_in,
    input  logic                        start,
    output logic                        ready,
    output logic                        done,
    output logic                        dir,
    output logic [STEPS_BITS-1:0]       pos,
    output logic [PULSE_NUM_BITS-1:0]   pg_pulse_num,
    output logic [PULSE_WIDTH_BITS-1:0] pg_pulse_width,
    output logic                        pg_trigger,
    input  logic                        pg_done
);

    localparam int unsigned CntBits =
        (DIR_SETUP_CYCLES > 0) ? $clog2(DIR_SETUP_CYCLES + 1) : 1;
    localparam logic [STEPS_BITS-1:0] MaxChunk = STEPS_BITS'((1 << PULSE_NUM_BITS) - 1);
    localparam logic [CntBits-1:0]    SetupLoad = CntBits'(DIR_SETUP_CYCLES);

    typedef enum logic [2:0] {
        StIdle,
        StDirSetup,
        StTrig,
        StWaitDone,
        StFinish
    } state_e;

    state_e                      state_q, state_d;
    logic                        dir_q, dir_d;
    logic [STEPS_BITS-1:0]       pos_q, pos_d;
    logic [STEPS_BITS-1:0]       rem_q, rem_d;
    logic [PULSE_NUM_BITS-1:0]   num_q, num_d;
    logic [PULSE_WIDTH_BITS-1:0] width_q, width_d;
    logic [CntBits-1:0]          cnt_q, cnt_d;

    logic [STEPS_BITS-1:0] mag;
    logic [STEPS_BITS-1:0] rem_after;
    logic [STEPS_BITS-1:0] chunk_ext;
    logic                  new_dir;

    function automatic logic [PULSE_NUM_BITS-1:0] chunk_of(input logic [STEPS_BITS-1:0] r);
        return (r > MaxChunk) ? PULSE_NUM_BITS'(MaxChunk) : PULSE_NUM_BITS'(r);
    endfunction

    // Unsigned magnitude: the most negative request maps to 2**(STEPS_BITS-1) without overflow.
    assign mag       = steps[STEPS_BITS-1] ? (~steps + STEPS_BITS'(1)) : steps;
    assign new_dir   = ~steps[STEPS_BITS-1];
    assign chunk_ext = STEPS_BITS'(num_q);
    assign rem_after = rem_q - chunk_ext;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        pos_d   = pos_q;
        rem_d   = rem_q;
        num_d   = num_q;
        width_d = width_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    rem_d   = mag;
                    width_d = (pulse_width_in == '0) ? PULSE_WIDTH_BITS'(1) : pulse_width_in;
                    if (steps == '0) begin
                        state_d = StFinish;
                    end else if (new_dir != dir_q && DIR_SETUP_CYCLES != 0) begin
                        dir_d   = new_dir;
                        cnt_d   = SetupLoad;
                        state_d = StDirSetup;
                    end else begin
                        dir_d   = new_dir;
                        num_d   = chunk_of(mag);
                        state_d = StTrig;
                    end
                end
            end
            StDirSetup: begin
                if (cnt_q <= CntBits'(1)) begin
                    num_d   = chunk_of(rem_q);
                    state_d = StTrig;
                end else begin
                    cnt_d = cnt_q - CntBits'(1);
                end
            end
            StTrig: begin
                // pg_done low means PulseGen has taken the chunk, whatever its enable cadence.
                if (!pg_done) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (pg_done) begin
                    rem_d = rem_after;
                    pos_d = dir_q ? (pos_q + chunk_ext) : (pos_q - chunk_ext);
                    if (rem_after == '0) begin
                        state_d = StFinish;
                    end else begin
                        num_d   = chunk_of(rem_after);
                        state_d = StTrig;
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            dir_q   <= 1'b1;
            pos_q   <= '0;
            rem_q   <= '0;
            num_q   <= '0;
            width_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
            rem_q   <= rem_d;
            num_q   <= num_d;
            width_q <= width_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready          = (state_q == StIdle);
    assign done           = (state_q == StFinish);
    assign pg_trigger     = (state_q == StTrig);
    assign dir            = dir_q;
    assign pos            = pos_q;
    assign pg_pulse_num   = num_q;
    assign pg_pulse_width = width_q;

endmodule
